traffic_lamp_monitor: RTL and testbench

//  Lamp-side end of the traffic controller interface: consumes the controller's 4-bit lamp word.

---
 rtl/traffic_lamp_monitor_pkg.sv | 39 +++
 rtl/traffic_flash_gen.sv | 34 +++
 rtl/traffic_lamp_monitor.sv | 175 +++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/traffic_lamp_monitor_pkg.sv
// Shared lamp codes, phase/fault encodings and FSM state type for the lamp monitor.
// A lamp word decodes to the tracking state it selects; any other word maps to S_FAULT.
package traffic_lamp_monitor_pkg;

    localparam logic [3:0] LAMP_RED      = 4'b1000;
    localparam logic [3:0] LAMP_AMBER    = 4'b0100;
    localparam logic [3:0] LAMP_GREEN    = 4'b0010;
    localparam logic [3:0] LAMP_DISABLED = 4'b1111;
    localparam logic [3:0] LAMP_OFF      = 4'b0000;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_RED   = 2'd1;
    localparam logic [1:0] PH_AMBER = 2'd2;
    localparam logic [1:0] PH_GREEN = 2'd3;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] FC_SEQUENCE = 3'd2;
    localparam logic [2:0] FC_SHORT    = 3'd3;
    localparam logic [2:0] FC_STUCK    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RED   = 3'd1,
        S_AMBER = 3'd2,
        S_GREEN = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    function automatic state_e code_to_state(input logic [3:0] code);
        case (code)
            LAMP_RED:   return S_RED;
            LAMP_AMBER: return S_AMBER;
            LAMP_GREEN: return S_GREEN;
            default:    return S_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/traffic_flash_gen.sv
// Fault flash divider: o_flash_on is the lamp state for the next output cycle,
// so it toggles one count before each half-period boundary. HALF must be >= 2.
module traffic_flash_gen #(
    parameter int HALF = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_flash_on
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_on;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_on  <= 1'b1;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_on  <= 1'b1;
        end else if (i_en) begin
            r_cnt <= (r_cnt == CW'(HALF - 1)) ? '0 : r_cnt + 1'b1;
            if (r_cnt == CW'(HALF - 2))
                r_on <= ~r_on;
        end
    end

    assign o_flash_on = r_on;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Lamp-side monitor: tracks phase/dwell of the controller lamp word, latches the first fault
// and flashes red until cleared. States: IDLE wait/resync | RED/AMBER/GREEN tracking | FAULT flash.
module traffic_lamp_monitor
    import traffic_lamp_monitor_pkg::*;
#(
    parameter int MIN_RED    = 10,
    parameter int MIN_AMBER  = 2,
    parameter int MIN_GREEN  = 8,
    parameter int MAX_DWELL  = 64,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [3:0]       i_lamp_in,
    input  logic             i_clr_fault,
    output logic [3:0]       o_lamp_out,
    output logic [1:0]       o_phase,
    output logic [CNT_W-1:0] o_dwell_cnt,
    output logic             o_fault,
    output logic [2:0]       o_fault_code
);

    state_e           r_state;
    logic [3:0]       r_lamp_out;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_dwell;
    logic             r_fault;
    logic [2:0]       r_fault_code;

    state_e           w_state_nxt;
    state_e           w_code_state;
    state_e           w_succ;
    logic [CNT_W-1:0] w_min;
    logic [CNT_W-1:0] w_dwell_inc;
    logic [CNT_W-1:0] w_dwell_nxt;
    logic [3:0]       w_lamp_nxt;
    logic [1:0]       w_phase_nxt;
    logic [2:0]       w_code_nxt;
    logic             w_flash_on;
    logic             w_flash_clr;

    assign w_code_state = code_to_state(i_lamp_in);
    assign w_dwell_inc  = r_dwell + 1'b1;

    always_comb begin
        w_succ = S_FAULT;
        w_min  = '0;
        case (r_state)
            S_RED:   begin w_succ = S_AMBER; w_min = CNT_W'(MIN_RED);   end
            S_AMBER: begin w_succ = S_GREEN; w_min = CNT_W'(MIN_AMBER); end
            S_GREEN: begin w_succ = S_RED;   w_min = CNT_W'(MIN_GREEN); end
            default: begin w_succ = S_FAULT; w_min = '0;                end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lamp_nxt  = r_lamp_out;
        w_dwell_nxt = r_dwell;
        w_code_nxt  = r_fault_code;
        case (r_state)
            S_IDLE: begin
                w_lamp_nxt  = LAMP_RED;
                w_dwell_nxt = '0;
                if (i_en && i_lamp_in != LAMP_DISABLED) begin
                    if (w_code_state != S_FAULT) begin
                        w_state_nxt = w_code_state;
                        w_lamp_nxt  = i_lamp_in;
                        w_dwell_nxt = CNT_W'(1);
                    end else begin
                        w_state_nxt = S_FAULT;
                        w_code_nxt  = FC_ILLEGAL;
                    end
                end
            end
            S_RED, S_AMBER, S_GREEN: begin
                if (!i_en || i_lamp_in == LAMP_DISABLED) begin
                    w_state_nxt = S_IDLE;
                    w_lamp_nxt  = LAMP_RED;
                    w_dwell_nxt = '0;
                end else if (w_code_state == S_FAULT) begin
                    w_state_nxt = S_FAULT;
                    w_lamp_nxt  = LAMP_RED;
                    w_code_nxt  = FC_ILLEGAL;
                end else if (w_code_state == r_state) begin
                    w_lamp_nxt  = i_lamp_in;
                    w_dwell_nxt = w_dwell_inc;
                    if (w_dwell_inc == CNT_W'(MAX_DWELL)) begin
                        w_state_nxt = S_FAULT;
                        w_lamp_nxt  = LAMP_RED;
                        w_code_nxt  = FC_STUCK;
                    end
                end else if (w_code_state == w_succ) begin
                    if (r_dwell >= w_min) begin
                        w_state_nxt = w_succ;
                        w_lamp_nxt  = i_lamp_in;
                        w_dwell_nxt = CNT_W'(1);
                    end else begin
                        w_state_nxt = S_FAULT;
                        w_lamp_nxt  = LAMP_RED;
                        w_code_nxt  = FC_SHORT;
                    end
                end else begin
                    w_state_nxt = S_FAULT;
                    w_lamp_nxt  = LAMP_RED;
                    w_code_nxt  = FC_SEQUENCE;
                end
            end
            S_FAULT: begin
                if (i_clr_fault) begin
                    w_state_nxt = S_IDLE;
                    w_lamp_nxt  = LAMP_RED;
                    w_dwell_nxt = '0;
                    w_code_nxt  = FC_NONE;
                end else begin
                    w_lamp_nxt = w_flash_on ? LAMP_RED : LAMP_OFF;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lamp_nxt  = LAMP_RED;
                w_dwell_nxt = '0;
                w_code_nxt  = FC_NONE;
            end
        endcase
    end

    always_comb begin
        w_phase_nxt = PH_IDLE;
        case (w_state_nxt)
            S_RED:   w_phase_nxt = PH_RED;
            S_AMBER: w_phase_nxt = PH_AMBER;
            S_GREEN: w_phase_nxt = PH_GREEN;
            default: w_phase_nxt = PH_IDLE;
        endcase
    end

    // Restart the flash on both fault entry and fault release.
    assign w_flash_clr = (r_state == S_FAULT) != (w_state_nxt == S_FAULT);

    traffic_flash_gen #(.HALF(FLASH_HALF)) u_flash (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_flash_clr),
        .i_en       (r_state == S_FAULT),
        .o_flash_on (w_flash_on)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_lamp_out   <= LAMP_RED;
            r_phase      <= PH_IDLE;
            r_dwell      <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_lamp_out   <= w_lamp_nxt;
            r_phase      <= w_phase_nxt;
            r_dwell      <= w_dwell_nxt;
            r_fault      <= (w_state_nxt == S_FAULT);
            r_fault_code <= w_code_nxt;
        end
    end

    assign o_lamp_out   = r_lamp_out;
    assign o_phase      = r_phase;
    assign o_dwell_cnt  = r_dwell;
    assign o_fault      = r_fault;
    assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor: normal cycling, each fault cause, flash pattern,
// clear, enable drop and asynchronous reset.
module tb_traffic_lamp_monitor;

    localparam logic [3:0] RED   = 4'b1000;
    localparam logic [3:0] AMBER = 4'b0100;
    localparam logic [3:0] GREEN = 4'b0010;
    localparam logic [3:0] DIS   = 4'b1111;
    localparam logic [3:0] OFF   = 4'b0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] lamp_in;
    logic       clr;
    logic [3:0] lamp_out;
    logic [1:0] phase;
    logic [7:0] dwell;
    logic       fault;
    logic [2:0] fault_code;

    int vectors = 0;
    int miscompares = 0;

    traffic_lamp_monitor dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_lamp_in    (lamp_in),
        .i_clr_fault  (clr),
        .o_lamp_out   (lamp_out),
        .o_phase      (phase),
        .o_dwell_cnt  (dwell),
        .o_fault      (fault),
        .o_fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic e, input logic [3:0] l, input logic c);
        en = e; lamp_in = l; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; lamp_in = RED; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (lamp_out !== RED) begin miscompares++; $display("FAIL reset_lamp: got %b expected %b", lamp_out, RED); end
        vectors++; if (phase !== 2'd0) begin miscompares++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        vectors++; if (dwell !== 8'd0) begin miscompares++; $display("FAIL reset_dwell: got %0d expected 0", dwell); end
        vectors++; if (fault !== 1'b0 || fault_code !== 3'd0) begin miscompares++; $display("FAIL reset_fault: got %b/%0d expected 0/0", fault, fault_code); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, DIS, 1'b0);
        vectors++; if (lamp_out !== RED || dwell !== 8'd0) begin miscompares++; $display("FAIL idle_disabled: got %b/%0d expected 1000/0", lamp_out, dwell); end
    endtask

    task automatic test_normal();
        logic [3:0] codes [3];
        int lens [3];
        codes[0] = RED; codes[1] = AMBER; codes[2] = GREEN;
        lens[0] = 10; lens[1] = 2; lens[2] = 8;
        for (int rep = 0; rep < 3; rep++) begin
            for (int p = 0; p < 3; p++) begin
                for (int k = 1; k <= lens[p]; k++) begin
                    drive(1'b1, codes[p], 1'b0);
                    vectors++; if (lamp_out !== codes[p]) begin miscompares++; $display("FAIL normal_lamp r%0d p%0d k%0d: got %b expected %b", rep, p, k, lamp_out, codes[p]); end
                    vectors++; if (dwell !== 8'(k)) begin miscompares++; $display("FAIL normal_dwell r%0d p%0d: got %0d expected %0d", rep, p, dwell, k); end
                    vectors++; if (phase !== 2'(p + 1)) begin miscompares++; $display("FAIL normal_phase r%0d p%0d: got %0d expected %0d", rep, p, phase, p + 1); end
                    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL normal_fault r%0d p%0d k%0d: got %b expected 0", rep, p, k, fault); end
                end
            end
        end
        drive(1'b0, GREEN, 1'b0);
    endtask

    task automatic test_short_and_flash();
        logic [3:0] exp_l;
        for (int k = 0; k < 10; k++) drive(1'b1, RED, 1'b0);
        drive(1'b1, AMBER, 1'b0);
        drive(1'b1, GREEN, 1'b0);
        vectors++; if (fault !== 1'b1 || fault_code !== 3'd3) begin miscompares++; $display("FAIL short_code: got %b/%0d expected 1/3", fault, fault_code); end
        vectors++; if (phase !== 2'd0 || dwell !== 8'd1) begin miscompares++; $display("FAIL short_frozen: got phase %0d dwell %0d expected 0/1", phase, dwell); end
        vectors++; if (lamp_out !== RED) begin miscompares++; $display("FAIL flash_0: got %b expected %b", lamp_out, RED); end
        for (int k = 1; k < 16; k++) begin
            drive(1'b1, (k % 2) ? AMBER : 4'b0110, 1'b0);
            exp_l = ((k / 4) % 2 == 0) ? RED : OFF;
            vectors++; if (lamp_out !== exp_l) begin miscompares++; $display("FAIL flash_%0d: got %b expected %b", k, lamp_out, exp_l); end
        end
        vectors++; if (fault_code !== 3'd3 || dwell !== 8'd1) begin miscompares++; $display("FAIL short_hold: got %0d/%0d expected 3/1", fault_code, dwell); end
        drive(1'b1, DIS, 1'b1);
        vectors++; if (fault !== 1'b0 || fault_code !== 3'd0 || lamp_out !== RED || dwell !== 8'd0) begin miscompares++; $display("FAIL short_clear: got %b/%0d/%b/%0d expected 0/0/1000/0", fault, fault_code, lamp_out, dwell); end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 3; k++) drive(1'b1, RED, 1'b0);
        drive(1'b1, 4'b0110, 1'b0);
        vectors++; if (fault !== 1'b1 || fault_code !== 3'd1) begin miscompares++; $display("FAIL illegal_code: got %b/%0d expected 1/1", fault, fault_code); end
        drive(1'b1, DIS, 1'b1);
        vectors++; if (fault !== 1'b0 || phase !== 2'd0) begin miscompares++; $display("FAIL illegal_clear: got %b/%0d expected 0/0", fault, phase); end
        drive(1'b1, RED, 1'b1);
        vectors++; if (phase !== 2'd1 || dwell !== 8'd1 || fault !== 1'b0) begin miscompares++; $display("FAIL clr_outside_fault: got %0d/%0d/%b expected 1/1/0", phase, dwell, fault); end
        drive(1'b1, 4'b1010, 1'b1);
        vectors++; if (fault !== 1'b1 || fault_code !== 3'd1) begin miscompares++; $display("FAIL fault_with_clr: got %b/%0d expected 1/1", fault, fault_code); end
        drive(1'b1, DIS, 1'b1);
    endtask

    task automatic test_stuck_and_sequence();
        for (int k = 1; k <= 63; k++) drive(1'b1, GREEN, 1'b0);
        vectors++; if (fault !== 1'b0 || dwell !== 8'd63) begin miscompares++; $display("FAIL stuck_63: got %b/%0d expected 0/63", fault, dwell); end
        drive(1'b1, GREEN, 1'b0);
        vectors++; if (fault !== 1'b1 || fault_code !== 3'd4 || dwell !== 8'd64) begin miscompares++; $display("FAIL stuck_64: got %b/%0d/%0d expected 1/4/64", fault, fault_code, dwell); end
        drive(1'b1, DIS, 1'b1);
        for (int k = 0; k < 10; k++) drive(1'b1, RED, 1'b0);
        drive(1'b1, GREEN, 1'b0);
        vectors++; if (fault !== 1'b1 || fault_code !== 3'd2) begin miscompares++; $display("FAIL sequence_code: got %b/%0d expected 1/2", fault, fault_code); end
        drive(1'b1, DIS, 1'b1);
    endtask

    task automatic test_en_drop();
        for (int k = 0; k < 10; k++) drive(1'b1, RED, 1'b0);
        drive(1'b1, AMBER, 1'b0);
        drive(1'b0, AMBER, 1'b0);
        vectors++; if (lamp_out !== RED || phase !== 2'd0 || dwell !== 8'd0 || fault !== 1'b0) begin miscompares++; $display("FAIL en_drop: got %b/%0d/%0d/%b expected 1000/0/0/0", lamp_out, phase, dwell, fault); end
        drive(1'b1, GREEN, 1'b0);
        vectors++; if (phase !== 2'd3 || dwell !== 8'd1 || lamp_out !== GREEN) begin miscompares++; $display("FAIL resync_green: got %0d/%0d/%b expected 3/1/0010", phase, dwell, lamp_out); end
        drive(1'b1, DIS, 1'b0);
        vectors++; if (phase !== 2'd0 || fault !== 1'b0 || lamp_out !== RED) begin miscompares++; $display("FAIL disabled_code: got %0d/%b/%b expected 0/0/1000", phase, fault, lamp_out); end
        drive(1'b1, OFF, 1'b0);
        vectors++; if (fault !== 1'b1 || fault_code !== 3'd1) begin miscompares++; $display("FAIL idle_illegal: got %b/%0d expected 1/1", fault, fault_code); end
        drive(1'b1, DIS, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) drive(1'b1, RED, 1'b0);
        #3 rst = 1'b1;
        #1;
        vectors++; if (lamp_out !== RED || phase !== 2'd0 || dwell !== 8'd0 || fault !== 1'b0) begin miscompares++; $display("FAIL async_reset: got %b/%0d/%0d/%b expected 1000/0/0/0", lamp_out, phase, dwell, fault); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, AMBER, 1'b0);
        vectors++; if (phase !== 2'd2 || dwell !== 8'd1) begin miscompares++; $display("FAIL post_reset_resync: got %0d/%0d expected 2/1", phase, dwell); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_short_and_flash();
        test_illegal();
        test_stuck_and_sequence();
        test_en_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
